// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Shared state encoding and sizing helper for the calculator arithmetic units.
// Rev    : 1.0
// ============================================================================
package calc_pkg;

    typedef enum logic [2:0] {
        START     = 3'b000,
        CHECK     = 3'b001,
        ADD       = 3'b010,
        SHIFT_DEC = 3'b011,
        CHECK_Z   = 3'b100,
        END       = 3'b101
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_cuadrado.sv
`default_nettype none
// ============================================================================
// Module : control_cuadrado
// Control FSM of the shift-and-add squarer; strobes are Moore-registered.
// Rev    : 1.0
// ============================================================================
module control_cuadrado
    import calc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    input  logic mr0,
    input  logic z,
    output logic ld,
    output logic add,
    output logic sh,
    output logic done,
    output logic busy
);

    state_t state;
    state_t nxt;

    function automatic state_t next_of(input state_t s, input logic i,
                                       input logic m, input logic zz);
        case (s)
            START:     return i  ? CHECK : START;
            CHECK:     return m  ? ADD   : SHIFT_DEC;
            ADD:       return SHIFT_DEC;
            SHIFT_DEC: return CHECK_Z;
            CHECK_Z:   return zz ? END   : CHECK;
            END:       return i  ? END   : START;
            default:   return START;
        endcase
    endfunction

    assign nxt = next_of(state, init, mr0, z);

    // Load is the only strobe that must act in the same cycle INIT is seen.
    assign ld = (state == START) && init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= START;
            add   <= 1'b0;
            sh    <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= nxt;
            add   <= (nxt == ADD);
            sh    <= (nxt == SHIFT_DEC);
            done  <= (nxt == END);
            busy  <= (nxt != START) && (nxt != END);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cuadrado_seq.sv
`default_nettype none
// ============================================================================
// Module : cuadrado_seq
// Sequential unsigned squarer, pp = a*a, one multiplier bit per iteration.
// Rev    : 1.0
// ============================================================================
module cuadrado_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic [WIDTH-1:0]     a,
    output logic [2*WIDTH-1:0]   pp,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = cnt_width(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("cuadrado_seq: WIDTH must be in 2..16");
        end
    endgenerate

    logic [2*WIDTH-1:0] md;
    logic [WIDTH-1:0]   mr;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic ld;
    logic add_s;
    logic sh_s;
    logic mr0;
    logic z;

    assign mr0 = mr[0];
    assign z   = (cnt == '0);
    assign pp  = acc;

    control_cuadrado u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (init),
        .mr0   (mr0),
        .z     (z),
        .ld    (ld),
        .add   (add_s),
        .sh    (sh_s),
        .done  (done),
        .busy  (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md  <= '0;
            mr  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (ld) begin
            md  <= {{WIDTH{1'b0}}, a};
            mr  <= a;
            acc <= '0;
            cnt <= CW'(WIDTH);
        end else begin
            // A square never exceeds 2*WIDTH bits, so the wrap is never taken.
            if (add_s) begin
                acc <= acc + md;
            end
            if (sh_s) begin
                md  <= md << 1;
                mr  <= mr >> 1;
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire
